// File: rtl/ps2_pkg.sv
// ps2_pkg: shared frame FSM encoding, STATUS bit positions and the position clamp helper
// for the PS/2 mouse receiver.
package ps2_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} frame_state_e;
    localparam int FRAME_LEN = 11;
    localparam int STS_L = 0;
    localparam int STS_R = 1;
    localparam int STS_M = 2;
    localparam int STS_SYNC = 3;
    localparam int STS_XS = 4;
    localparam int STS_YS = 5;
    localparam int STS_XO = 6;
    localparam int STS_YO = 7;

    function automatic logic [7:0] clamp_pos(input logic signed [10:0] v, input logic [7:0] max);
        return v < 0 ? 8'd0 : v > $signed({3'b000, max}) ? max : v[7:0];
    endfunction
endpackage

// File: rtl/ps2_byte_rx.sv
// ps2_byte_rx: synchronises and glitch-filters PS2_CLK/PS2_DATA, deframes one 11-bit
// device-to-host frame per byte and flags parity, stop-bit and timeout errors.
module ps2_byte_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err
);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    // index 0 is the clock line, index 1 the data line
    logic [1:0] s1_q, s2_q, filt_q, filt_d;
    logic [1:0][FW-1:0] fcnt_q, fcnt_d;
    frame_state_e state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic bit_edge, data_bit;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q <= 2'b11;
            s2_q <= 2'b11;
            filt_q <= 2'b11;
            fcnt_q <= '0;
            state_q <= ST_IDLE;
            cnt_q <= '0;
            shift_q <= '0;
            par_ok_q <= 1'b0;
            tmo_q <= '0;
        end else begin
            s1_q <= {ps2_data, ps2_clk};
            s2_q <= s1_q;
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
            state_q <= state_d;
            cnt_q <= cnt_d;
            shift_q <= shift_d;
            par_ok_q <= par_ok_d;
            tmo_q <= tmo_d;
        end
    end

    // a level is accepted only after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        for (int i = 0; i < 2; i++) begin
            if (s2_q[i] != filt_q[i]) begin
                if (fcnt_q[i] == FW'(FILTER_LEN - 1)) filt_d[i] = s2_q[i];
                else fcnt_d[i] = fcnt_q[i] + 1'b1;
            end
        end
    end

    assign bit_edge = filt_q[0] & ~filt_d[0];
    assign data_bit = filt_q[1];
    assign rx_byte = shift_q;

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        shift_d = shift_q;
        par_ok_d = par_ok_q;
        tmo_d = '0;
        byte_valid = 1'b0;
        frame_err = 1'b0;
        if (bit_edge) begin
            case (state_q)
                ST_IDLE: begin
                    state_d = data_bit ? ST_IDLE : ST_DATA;
                    cnt_d = '0;
                end
                ST_DATA: begin
                    shift_d = {data_bit, shift_q[7:1]};
                    cnt_d = cnt_q + 1'b1;
                    state_d = cnt_q == 3'(FRAME_LEN - 4) ? ST_PARITY : ST_DATA;
                end
                ST_PARITY: begin
                    par_ok_d = ^{shift_q, data_bit};
                    state_d = ST_STOP;
                end
                default: begin
                    state_d = ST_IDLE;
                    byte_valid = data_bit & par_ok_q;
                    frame_err = ~(data_bit & par_ok_q);
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            if (tmo_q == TW'(TIMEOUT - 1)) begin
                state_d = ST_IDLE;
                frame_err = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end
endmodule

// File: rtl/ps2_mouse_rx.sv
// ps2_mouse_rx: assembles 3-byte PS/2 mouse packets into STATUS/DX/DY registers with a
// PACKET_VALID strobe; define PS2_POS_TRACK_EN for the clamped absolute position tracker.
module ps2_mouse_rx
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT = 50000,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       PS2_CLK,
    input  logic       PS2_DATA,
    output logic [7:0] MOUSE_STATUS,
    output logic [7:0] MOUSE_DX,
    output logic [7:0] MOUSE_DY,
    output logic [7:0] MOUSE_X,
    output logic [7:0] MOUSE_Y,
    output logic       PACKET_VALID,
    output logic       FRAME_ERR
);
    logic [7:0] rx_byte;
    logic byte_valid, frame_err;
    logic [1:0] idx_q, idx_d;
    logic [7:0] hold0_q, hold0_d, hold1_q, hold1_d;
    logic [7:0] status_q, status_d, dx_q, dx_d, dy_q, dy_d;
    logic pv_q, pv_d, fe_q, fe_d;

    ps2_byte_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) u_byte_rx (
        .CLK(CLK),
        .RESET(RESET),
        .ps2_clk(PS2_CLK),
        .ps2_data(PS2_DATA),
        .rx_byte(rx_byte),
        .byte_valid(byte_valid),
        .frame_err(frame_err)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            idx_q <= '0;
            hold0_q <= '0;
            hold1_q <= '0;
            status_q <= '0;
            dx_q <= '0;
            dy_q <= '0;
            pv_q <= 1'b0;
            fe_q <= 1'b0;
        end else begin
            idx_q <= idx_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            status_q <= status_d;
            dx_q <= dx_d;
            dy_q <= dy_d;
            pv_q <= pv_d;
            fe_q <= fe_d;
        end
    end

    // bytes without the always-one sync bit cannot start a packet and are dropped
    always_comb begin
        idx_d = idx_q;
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        status_d = status_q;
        dx_d = dx_q;
        dy_d = dy_q;
        pv_d = 1'b0;
        fe_d = frame_err;
        if (frame_err) begin
            idx_d = '0;
        end else if (byte_valid) begin
            if (idx_q == 2'd0) begin
                hold0_d = rx_byte[STS_SYNC] ? rx_byte : hold0_q;
                idx_d = rx_byte[STS_SYNC] ? 2'd1 : 2'd0;
            end else if (idx_q == 2'd1) begin
                hold1_d = rx_byte;
                idx_d = 2'd2;
            end else begin
                status_d = hold0_q;
                dx_d = hold1_q;
                dy_d = rx_byte;
                pv_d = 1'b1;
                idx_d = '0;
            end
        end
    end

    assign MOUSE_STATUS = status_q;
    assign MOUSE_DX = dx_q;
    assign MOUSE_DY = dy_q;
    assign PACKET_VALID = pv_q;
    assign FRAME_ERR = fe_q;

`ifdef PS2_POS_TRACK_EN
    logic [7:0] x_q, x_d, y_q, y_d;
    logic signed [10:0] nx, ny;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            x_q <= 8'(X_MAX / 2);
            y_q <= 8'(Y_MAX / 2);
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // screen Y grows downward, so a positive mouse dY moves the pointer up
    always_comb begin
        nx = $signed({3'b000, x_q}) + $signed({{3{hold0_q[STS_XS]}}, hold1_q});
        ny = $signed({3'b000, y_q}) - $signed({{3{hold0_q[STS_YS]}}, rx_byte});
        x_d = pv_d && !hold0_q[STS_XO] ? clamp_pos(nx, 8'(X_MAX)) : x_q;
        y_d = pv_d && !hold0_q[STS_YO] ? clamp_pos(ny, 8'(Y_MAX)) : y_q;
    end

    assign MOUSE_X = x_q;
    assign MOUSE_Y = y_q;
`else
    logic [31:0] unused_max;
    assign unused_max = 32'(X_MAX + Y_MAX);
    assign MOUSE_X = '0;
    assign MOUSE_Y = '0;
`endif
endmodule
